// File: rtl/ccff_pkg.sv
// Shared types and helpers for the CCFF configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_t;

  // Number of bitstream words needed to fill one pass of the chain.
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and hands it out LSB-first, one bit per shift,
// flagging the last bit of the word so the sequencer knows when to refetch.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              shift,
  output logic              head_bit,
  output logic              last
);

  localparam int WB_W = $clog2(WORD_W + 1);
  localparam logic [WB_W-1:0] WB_FULL = WB_W'(WORD_W);
  localparam logic [WB_W-1:0] WB_ONE  = WB_W'(1);

  logic [WORD_W-1:0] sr;
  logic [WB_W-1:0]   wordbits;

  // A fresh word replaces whatever is left of the previous one; leftover bits
  // of a truncated final word are simply overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= '0;
      wordbits <= '0;
    end else if (load) begin
      sr       <= data;
      wordbits <= WB_FULL;
    end else if (shift) begin
      sr       <= sr >> 1;
      wordbits <= wordbits - WB_ONE;
    end
  end

  assign head_bit = sr[0];
  assign last     = (wordbits == WB_ONE);

endmodule

// File: rtl/ccff_chain_loader.sv
// Programs a tile's configuration chain from a valid/ready bitstream and
// optionally re-sends the stream to check what comes out of the chain tail.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 160,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic              bs_valid,
  input  logic [WORD_W-1:0] bs_data,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              config_readback,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);

  ccff_state_t      state_q, state_d;
  logic [BIT_W-1:0] bitcnt;
  logic             pass;
  logic             verify;
  logic             cmp_en;
  logic             begin_seq;
  logic             load;
  logic             shift;
  logic             ser_bit;
  logic             word_last;
  logic             pass_end;

  assign pass_end = (bitcnt == LAST_BIT);
  assign busy     = (state_q != IDLE);

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk      (prog_clk),
    .rst_n    (pReset_n),
    .load     (load),
    .data     (bs_data),
    .shift    (shift),
    .head_bit (ser_bit),
    .last     (word_last)
  );

  // Next-state and handshake decode; abort overrides everything and returns to IDLE.
  always_comb begin
    state_d   = state_q;
    bs_ready  = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    begin_seq = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          begin_seq = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        bs_ready = 1'b1;
        if (bs_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (pass_end) begin
          state_d = (verify && !pass) ? FETCH : DONE;
        end else if (word_last) begin
          state_d = FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      bs_ready  = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      begin_seq = 1'b0;
    end
  end

  // State register plus the registered chain drive; the chain only sees a bit when enable is high.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state_q       <= IDLE;
      ccff_head     <= 1'b0;
      config_enable <= 1'b0;
      cmp_en        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ccff_head     <= shift & ser_bit;
      config_enable <= shift;
      cmp_en        <= shift & pass;
    end
  end

  // Pass bookkeeping: bit position within the pass and which pass is running.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      bitcnt <= '0;
      pass   <= 1'b0;
      verify <= 1'b0;
    end else if (begin_seq) begin
      bitcnt <= '0;
      pass   <= 1'b0;
      verify <= verify_en;
    end else if (shift) begin
      if (pass_end) begin
        bitcnt <= '0;
        if (verify && !pass) begin
          pass <= 1'b1;
        end
      end else begin
        bitcnt <= bitcnt + BIT_ONE;
      end
    end
  end

  // Readback flag rises as the second pass begins and stays up through DONE.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      config_readback <= 1'b0;
    end else if (state_d == IDLE) begin
      config_readback <= 1'b0;
    end else if (shift && pass_end && verify && !pass) begin
      config_readback <= 1'b1;
    end
  end

  // Tail-versus-head comparison runs one cycle behind each second-pass shift,
  // aligned with the registered head bit; the count sticks at all-ones.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      err_cnt <= '0;
    end else if (begin_seq) begin
      err_cnt <= '0;
    end else if (cmp_en && !abort && (ccff_tail != ccff_head) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 160-bit instance and a 13-bit
// instance with a 3-bit error counter, each feeding a model chain.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int LEN_A = 160;
  localparam int LEN_B = 13;
  localparam int W     = 8;
  localparam int CNT_A = $clog2(LEN_A + 1);
  localparam int CNT_B = 3;

  typedef struct {
    bit sel;
    bit verify;
    int mode;
    bit stall;
    int exp_en;
    int exp_done;
    int exp_err;
    int exp_rb;
    int exp_rb_first;
    int exp_rdy;
  } row_t;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic pReset_n;
  logic start_a, verify_a, abort_a, valid_a, ready_a, head_a, tail_a, en_a, rb_a, busy_a, done_a;
  logic [W-1:0] data_a;
  logic [CNT_A-1:0] err_a;
  logic start_b, verify_b, abort_b, valid_b, ready_b, head_b, tail_b, en_b, rb_b, busy_b, done_b;
  logic [W-1:0] data_b;
  logic [CNT_B-1:0] err_b;

  logic [LEN_A-1:0] chain_a = '0;
  logic [LEN_B-1:0] chain_b = '0;

  ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(W), .CNT_W(CNT_A)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_a), .verify_en(verify_a),
    .abort(abort_a), .bs_valid(valid_a), .bs_data(data_a), .bs_ready(ready_a),
    .ccff_head(head_a), .ccff_tail(tail_a), .config_enable(en_a),
    .config_readback(rb_a), .busy(busy_a), .done(done_a), .err_cnt(err_a));

  ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(W), .CNT_W(CNT_B)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_b), .verify_en(verify_b),
    .abort(abort_b), .bs_valid(valid_b), .bs_data(data_b), .bs_ready(ready_b),
    .ccff_head(head_b), .ccff_tail(tail_b), .config_enable(en_b),
    .config_readback(rb_b), .busy(busy_b), .done(done_b), .err_cnt(err_b));

  // Model chains: shift toward index 0 while enabled, tail is index 0.
  always @(posedge prog_clk) if (en_a) chain_a <= {head_a, chain_a[LEN_A-1:1]};
  always @(posedge prog_clk) if (en_b) chain_b <= {head_b, chain_b[LEN_B-1:1]};
  assign tail_a = chain_a[0];
  assign tail_b = chain_b[0];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, en_cnt, done_cnt, done_cyc, rb_cnt, rb_first, rdy_cnt, stall_en_cnt;
  bit sel, prev_stall, stall_arm;
  int stall_left;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  row_t rows[6];

  task automatic checkOutput(input string name, input logic [LEN_A-1:0] act, input logic [LEN_A-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_counters();
    cyc = 0; en_cnt = 0; done_cnt = 0; done_cyc = -1; rb_cnt = 0;
    rb_first = -1; rdy_cnt = 0; stall_en_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic sample();
    logic en, rdy, vld, dn, rb;
    en  = sel ? en_b    : en_a;
    rdy = sel ? ready_b : ready_a;
    vld = sel ? valid_b : valid_a;
    dn  = sel ? done_b  : done_a;
    rb  = sel ? rb_b    : rb_a;
    if (en) en_cnt++;
    if (dn) begin done_cnt++; done_cyc = cyc; end
    if (rb) begin if (rb_cnt == 0) rb_first = cyc; rb_cnt++; end
    if (rdy) rdy_cnt++;
    if (prev_stall && en) stall_en_cnt++;
    prev_stall = rdy && !vld;
  endtask

  task automatic drive_sources();
    if (stall_arm && qa.size() == 10 && ready_a) begin
      stall_left = 5;
      stall_arm  = 1'b0;
    end
    valid_a = (qa.size() > 0) && (stall_left == 0);
    data_a  = (qa.size() > 0) ? qa[0] : 8'h00;
    if (stall_left > 0) stall_left--;
    valid_b = (qb.size() > 0);
    data_b  = (qb.size() > 0) ? qb[0] : 8'h00;
  endtask

  task automatic tick();
    bit hs_a, hs_b;
    #1;
    sample();
    hs_a = valid_a && ready_a;
    hs_b = valid_b && ready_b;
    @(posedge prog_clk);
    #1;
    cyc++;
    if (hs_a) qa.delete(0);
    if (hs_b) qb.delete(0);
    drive_sources();
  endtask

  // Builds the stream for one row, runs it to completion and compares the tallies.
  task automatic applyStimulus(input row_t r, input int idx);
    logic [W-1:0] p0[$];
    logic [W-1:0] p1[$];
    logic [W-1:0] wd;
    logic [LEN_A-1:0] exp_chain;
    int len, wpp;
    sel = r.sel;
    len = r.sel ? LEN_B : LEN_A;
    wpp = words_per_pass(len, W);
    for (int i = 0; i < wpp; i++) begin
      if (r.sel) p0.push_back((i == 0) ? 8'hA5 : 8'hFF);
      else       p0.push_back(8'($urandom));
    end
    for (int i = 0; i < wpp; i++) begin
      wd = p0[i];
      if (r.mode == 1 && i == 3) wd[2] = ~wd[2];
      if (r.mode == 2) wd = ~wd;
      p1.push_back(wd);
    end
    exp_chain = '0;
    for (int k = 0; k < len; k++) begin
      wd = r.verify ? p1[k / W] : p0[k / W];
      exp_chain[k] = wd[k % W];
    end
    qa.delete(); qb.delete();
    for (int i = 0; i < wpp; i++) if (r.sel) qb.push_back(p0[i]); else qa.push_back(p0[i]);
    if (r.verify)
      for (int i = 0; i < wpp; i++) if (r.sel) qb.push_back(p1[i]); else qa.push_back(p1[i]);
    stall_arm = r.stall; stall_left = 0;
    reset_counters();
    if (r.sel) begin start_b = 1'b1; verify_b = r.verify; end
    else       begin start_a = 1'b1; verify_a = r.verify; end
    drive_sources();
    tick();
    start_a = 1'b0; start_b = 1'b0; verify_a = 1'b0; verify_b = 1'b0;
    while (done_cnt == 0 && cyc < 2000) tick();
    tick(); tick();
    #1;
    checkOutput($sformatf("row%0d en_cycles", idx), en_cnt, r.exp_en);
    checkOutput($sformatf("row%0d done_pulses", idx), done_cnt, 1);
    checkOutput($sformatf("row%0d done_cycle", idx), done_cyc, r.exp_done);
    checkOutput($sformatf("row%0d err_cnt", idx), r.sel ? err_b : err_a, r.exp_err);
    checkOutput($sformatf("row%0d readback_cycles", idx), rb_cnt, r.exp_rb);
    checkOutput($sformatf("row%0d readback_first", idx), rb_first, r.exp_rb_first);
    checkOutput($sformatf("row%0d ready_cycles", idx), rdy_cnt, r.exp_rdy);
    checkOutput($sformatf("row%0d stall_enable", idx), stall_en_cnt, 0);
    checkOutput($sformatf("row%0d chain", idx), r.sel ? chain_b : chain_a, exp_chain);
    checkOutput($sformatf("row%0d busy_after", idx), r.sel ? busy_b : busy_a, 0);
  endtask

  initial begin
    rows[0] = '{1'b0, 1'b0, 0, 1'b0, 160, 181, 0,   0,  -1, 20};
    rows[1] = '{1'b1, 1'b0, 0, 1'b0,  13,  16, 0,   0,  -1,  2};
    rows[2] = '{1'b1, 1'b1, 0, 1'b0,  26,  31, 0,  16,  16,  4};
    rows[3] = '{1'b0, 1'b1, 1, 1'b0, 320, 361, 1, 181, 181, 40};
    rows[4] = '{1'b1, 1'b1, 2, 1'b0,  26,  31, 7,  16,  16,  4};
    rows[5] = '{1'b0, 1'b0, 0, 1'b1, 160, 186, 0,   0,  -1, 25};

    pReset_n = 1'b0;
    start_a = 0; verify_a = 0; abort_a = 0; start_b = 0; verify_b = 0; abort_b = 0;
    sel = 1'b0; stall_arm = 1'b0; stall_left = 0;
    reset_counters();
    drive_sources();
    tick(); tick();
    #1;
    checkOutput("reset_a", {ready_a, head_a, en_a, rb_a, busy_a, done_a, err_a}, 0);
    checkOutput("reset_b", {ready_b, head_b, en_b, rb_b, busy_b, done_b, err_b}, 0);
    pReset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(rows[i], i);

    // Abort in the middle of word 4 on the long chain.
    sel = 1'b0; reset_counters(); qa.delete();
    for (int i = 0; i < 20; i++) qa.push_back(8'($urandom));
    start_a = 1'b1; drive_sources(); tick(); start_a = 1'b0;
    while (cyc < 40) tick();
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    #1;
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_enable", en_a, 0);
    checkOutput("abort_ready", ready_a, 0);
    repeat (5) tick();
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_err", err_a, 0);
    qa.delete(); drive_sources();

    // Abort during the verify pass of an inverted resend: count must freeze at 2.
    sel = 1'b1; reset_counters(); qb.delete();
    qb.push_back(8'hA5); qb.push_back(8'hFF); qb.push_back(8'h5A); qb.push_back(8'h00);
    start_b = 1'b1; verify_b = 1'b1; drive_sources(); tick(); start_b = 1'b0; verify_b = 1'b0;
    while (cyc < 20) tick();
    abort_b = 1'b1; tick(); abort_b = 1'b0;
    repeat (3) tick();
    #1;
    checkOutput("abort_verify_err_hold", err_b, 2);
    checkOutput("abort_verify_readback", rb_b, 0);
    checkOutput("abort_verify_no_done", done_cnt, 0);
    qb.delete(); drive_sources();

    // Reset while waiting in FETCH of the verify pass.
    reset_counters(); qb.delete();
    qb.push_back(8'hA5); qb.push_back(8'hFF); qb.push_back(8'h5A); qb.push_back(8'h00);
    start_b = 1'b1; verify_b = 1'b1; drive_sources(); tick(); start_b = 1'b0; verify_b = 1'b0;
    while (cyc < 25) tick();
    #1;
    checkOutput("pre_reset_state", {busy_b, rb_b, ready_b}, 3'b111);
    checkOutput("pre_reset_err", err_b, 7);
    pReset_n = 1'b0; tick(); pReset_n = 1'b1;
    qb.delete(); drive_sources();
    #1;
    checkOutput("reset_mid_b", {ready_b, head_b, en_b, rb_b, busy_b, done_b, err_b}, 0);
    repeat (3) tick();
    checkOutput("reset_mid_no_done", done_cnt, 0);

    applyStimulus(rows[0], 6);
    applyStimulus(rows[1], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
